// File: rtl/redmule_mesh_pkg.sv
// Shared AXI parameters and channel/bundle types for the RedMulE mesh NoC
// (tile side) and the L2 port, whose ID carries the tile-index prefix.
package redmule_mesh_pkg;

  localparam int unsigned AXI_NOC_ID_W = 4;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STRB_W       = DATA_W / 8;
  localparam int unsigned AXI_NOC_U_W  = 1;
  localparam int unsigned L2_N_TILES   = 4;
  localparam int unsigned L2_ID_W      = AXI_NOC_ID_W + $clog2(L2_N_TILES);

  typedef struct packed {
    logic [AXI_NOC_ID_W-1:0] id;
    logic [ADDR_W-1:0]       addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [AXI_NOC_U_W-1:0]  user;
  } axi_noc_ax_chan_t;

  typedef struct packed {
    logic [L2_ID_W-1:0]     id;
    logic [ADDR_W-1:0]      addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic [3:0]             cache;
    logic [2:0]             prot;
    logic [AXI_NOC_U_W-1:0] user;
  } axi_l2_ax_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0]      data;
    logic [STRB_W-1:0]      strb;
    logic                   last;
    logic [AXI_NOC_U_W-1:0] user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AXI_NOC_ID_W-1:0] id;
    logic [1:0]              resp;
    logic [AXI_NOC_U_W-1:0]  user;
  } axi_noc_b_chan_t;

  typedef struct packed {
    logic [L2_ID_W-1:0]     id;
    logic [1:0]             resp;
    logic [AXI_NOC_U_W-1:0] user;
  } axi_l2_b_chan_t;

  typedef struct packed {
    logic [AXI_NOC_ID_W-1:0] id;
    logic [DATA_W-1:0]       data;
    logic [1:0]              resp;
    logic                    last;
    logic [AXI_NOC_U_W-1:0]  user;
  } axi_noc_r_chan_t;

  typedef struct packed {
    logic [L2_ID_W-1:0]     id;
    logic [DATA_W-1:0]      data;
    logic [1:0]             resp;
    logic                   last;
    logic [AXI_NOC_U_W-1:0] user;
  } axi_l2_r_chan_t;

  typedef struct packed {
    axi_noc_ax_chan_t aw;
    logic             aw_valid;
    axi_w_chan_t      w;
    logic             w_valid;
    logic             b_ready;
    axi_noc_ax_chan_t ar;
    logic             ar_valid;
    logic             r_ready;
  } axi_noc_req_t;

  typedef struct packed {
    logic            aw_ready;
    logic            ar_ready;
    logic            w_ready;
    logic            b_valid;
    axi_noc_b_chan_t b;
    logic            r_valid;
    axi_noc_r_chan_t r;
  } axi_noc_rsp_t;

  typedef struct packed {
    axi_l2_ax_chan_t aw;
    logic            aw_valid;
    axi_w_chan_t     w;
    logic            w_valid;
    logic            b_ready;
    axi_l2_ax_chan_t ar;
    logic            ar_valid;
    logic            r_ready;
  } axi_l2_vip_req_t;

  typedef struct packed {
    logic           aw_ready;
    logic           ar_ready;
    logic           w_ready;
    logic           b_valid;
    axi_l2_b_chan_t b;
    logic           r_valid;
    axi_l2_r_chan_t r;
  } axi_l2_vip_rsp_t;

endpackage

// File: rtl/redmule_mesh_rr_arb.sv
// Round-robin arbiter with a zero-latency grant; once a grant is shown
// downstream and stalls, it is held until the handshake completes.
module redmule_mesh_rr_arb #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             block_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam int NI = int'(N);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             lock_q, lock_d;

  always_comb begin
    valid_o    = 1'b0;
    idx_o      = lock_idx_q;
    if (lock_q) begin
      valid_o = 1'b1;
    end else if (!block_i) begin
      for (int off = 0; off < NI; off++) begin
        if (!valid_o && req_i[(int'(ptr_q) + off) % NI]) begin
          valid_o = 1'b1;
          idx_o   = IDX_W'((int'(ptr_q) + off) % NI);
        end
      end
    end
    lock_d     = valid_o && !ready_i;
    lock_idx_d = idx_o;
    ptr_d      = ptr_q;
    if (valid_o && ready_i) begin
      ptr_d = (int'(idx_o) == NI - 1) ? '0 : idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/redmule_mesh_l2_axi_mux.sv
// N_TILES-to-1 AXI4 mux onto the shared L2 port: round-robin AW/AR with the
// tile index prefixed to the ID, W routed in AW order, B/R routed by prefix.
module redmule_mesh_l2_axi_mux
  import redmule_mesh_pkg::*;
#(
  parameter int unsigned N_TILES     = 4,
  parameter int unsigned SLV_ID_W    = AXI_NOC_ID_W,
  parameter int unsigned MST_ID_W    = SLV_ID_W + $clog2(N_TILES),
  parameter int unsigned MAX_W_TRANS = 8,
  parameter type         slv_req_t   = axi_noc_req_t,
  parameter type         slv_rsp_t   = axi_noc_rsp_t,
  parameter type         mst_req_t   = axi_l2_vip_req_t,
  parameter type         mst_rsp_t   = axi_l2_vip_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  slv_req_t [N_TILES-1:0] slv_req_i,
  output slv_rsp_t [N_TILES-1:0] slv_rsp_o,
  output mst_req_t               mst_req_o,
  input  mst_rsp_t               mst_rsp_i,
  output logic                   route_err_o
);

  localparam int unsigned IDX_W = $clog2(N_TILES);
  localparam int unsigned PTR_W = $clog2(MAX_W_TRANS);
  localparam int unsigned CNT_W = $clog2(MAX_W_TRANS + 1);

  logic               live;
  logic [N_TILES-1:0] aw_req, ar_req;
  logic               aw_arb_vld, ar_arb_vld, aw_vld, ar_vld, w_vld;
  logic [IDX_W-1:0]   aw_idx, ar_idx, w_head, b_idx, r_idx;
  logic               push, pop, fifo_full, fifo_empty;
  logic [IDX_W-1:0]   wfifo_q [MAX_W_TRANS];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               route_err_q, route_err_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == int'(MAX_W_TRANS) - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Nothing is offered in either direction while reset is held.
  assign live = ~rst_i;

  always_comb begin
    for (int t = 0; t < int'(N_TILES); t++) begin
      aw_req[t] = slv_req_i[t].aw_valid;
      ar_req[t] = slv_req_i[t].ar_valid;
    end
  end

  redmule_mesh_rr_arb #(.N(N_TILES), .IDX_W(IDX_W)) u_aw_arb (
    .clk_i, .rst_i, .req_i(aw_req), .block_i(fifo_full),
    .ready_i(mst_rsp_i.aw_ready), .valid_o(aw_arb_vld), .idx_o(aw_idx)
  );

  redmule_mesh_rr_arb #(.N(N_TILES), .IDX_W(IDX_W)) u_ar_arb (
    .clk_i, .rst_i, .req_i(ar_req), .block_i(1'b0),
    .ready_i(mst_rsp_i.ar_ready), .valid_o(ar_arb_vld), .idx_o(ar_idx)
  );

  assign aw_vld     = live & aw_arb_vld;
  assign ar_vld     = live & ar_arb_vld;
  assign fifo_full  = (cnt_q == CNT_W'(MAX_W_TRANS));
  assign fifo_empty = (cnt_q == '0);
  assign w_head     = wfifo_q[rd_ptr_q];
  assign w_vld      = live & ~fifo_empty & slv_req_i[w_head].w_valid;
  assign push       = aw_vld & mst_rsp_i.aw_ready;
  assign pop        = w_vld & mst_rsp_i.w_ready & slv_req_i[w_head].w.last;
  assign b_idx      = mst_rsp_i.b.id[MST_ID_W-1 -: IDX_W];
  assign r_idx      = mst_rsp_i.r.id[MST_ID_W-1 -: IDX_W];

  always_comb begin
    mst_req_o   = '0;
    slv_rsp_o   = '0;
    route_err_d = route_err_q;

    mst_req_o.aw_valid   = aw_vld;
    mst_req_o.aw.id      = {aw_idx, slv_req_i[aw_idx].aw.id};
    mst_req_o.aw.addr    = slv_req_i[aw_idx].aw.addr;
    mst_req_o.aw.len     = slv_req_i[aw_idx].aw.len;
    mst_req_o.aw.size    = slv_req_i[aw_idx].aw.size;
    mst_req_o.aw.burst   = slv_req_i[aw_idx].aw.burst;
    mst_req_o.aw.cache   = slv_req_i[aw_idx].aw.cache;
    mst_req_o.aw.prot    = slv_req_i[aw_idx].aw.prot;
    mst_req_o.aw.user    = slv_req_i[aw_idx].aw.user;
    if (aw_vld) slv_rsp_o[aw_idx].aw_ready = mst_rsp_i.aw_ready;

    mst_req_o.ar_valid   = ar_vld;
    mst_req_o.ar.id      = {ar_idx, slv_req_i[ar_idx].ar.id};
    mst_req_o.ar.addr    = slv_req_i[ar_idx].ar.addr;
    mst_req_o.ar.len     = slv_req_i[ar_idx].ar.len;
    mst_req_o.ar.size    = slv_req_i[ar_idx].ar.size;
    mst_req_o.ar.burst   = slv_req_i[ar_idx].ar.burst;
    mst_req_o.ar.cache   = slv_req_i[ar_idx].ar.cache;
    mst_req_o.ar.prot    = slv_req_i[ar_idx].ar.prot;
    mst_req_o.ar.user    = slv_req_i[ar_idx].ar.user;
    if (ar_vld) slv_rsp_o[ar_idx].ar_ready = mst_rsp_i.ar_ready;

    mst_req_o.w       = slv_req_i[w_head].w;
    mst_req_o.w_valid = w_vld;
    if (live && !fifo_empty) slv_rsp_o[w_head].w_ready = mst_rsp_i.w_ready;

    // Response payloads are broadcast; only the addressed tile sees valid.
    for (int t = 0; t < int'(N_TILES); t++) begin
      slv_rsp_o[t].b.id   = mst_rsp_i.b.id[SLV_ID_W-1:0];
      slv_rsp_o[t].b.resp = mst_rsp_i.b.resp;
      slv_rsp_o[t].b.user = mst_rsp_i.b.user;
      slv_rsp_o[t].r.id   = mst_rsp_i.r.id[SLV_ID_W-1:0];
      slv_rsp_o[t].r.data = mst_rsp_i.r.data;
      slv_rsp_o[t].r.resp = mst_rsp_i.r.resp;
      slv_rsp_o[t].r.last = mst_rsp_i.r.last;
      slv_rsp_o[t].r.user = mst_rsp_i.r.user;
    end
    if (live) begin
      if (int'(b_idx) < int'(N_TILES)) begin
        slv_rsp_o[b_idx].b_valid = mst_rsp_i.b_valid;
        mst_req_o.b_ready        = slv_req_i[b_idx].b_ready;
      end else begin
        mst_req_o.b_ready = 1'b1;
        route_err_d       = route_err_d | mst_rsp_i.b_valid;
      end
      if (int'(r_idx) < int'(N_TILES)) begin
        slv_rsp_o[r_idx].r_valid = mst_rsp_i.r_valid;
        mst_req_o.r_ready        = slv_req_i[r_idx].r_ready;
      end else begin
        mst_req_o.r_ready = 1'b1;
        route_err_d       = route_err_d | mst_rsp_i.r_valid;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      route_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      route_err_q <= route_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) wfifo_q[wr_ptr_q] <= aw_idx;
  end

  assign route_err_o = route_err_q;

endmodule

// File: tb/tb_redmule_mesh_l2_axi_mux.sv
// Directed and randomized bench for redmule_mesh_l2_axi_mux: a 4-tile
// instance with a 2-deep W FIFO and a 3-tile instance for out-of-range routes.
module tb_redmule_mesh_l2_axi_mux;
  import redmule_mesh_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  axi_noc_req_t [3:0]    sreq;
  axi_noc_rsp_t [3:0]    srsp;
  axi_l2_vip_req_t       mreq;
  axi_l2_vip_rsp_t       mrsp;
  logic                  rerr;
  axi_noc_req_t [2:0]    sreq3;
  axi_noc_rsp_t [2:0]    srsp3;
  axi_l2_vip_req_t       mreq3;
  axi_l2_vip_rsp_t       mrsp3;
  logic                  rerr3;

  int checks = 0;
  int failures = 0;

  redmule_mesh_l2_axi_mux #(.N_TILES(4), .MAX_W_TRANS(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .slv_req_i(sreq), .slv_rsp_o(srsp),
    .mst_req_o(mreq), .mst_rsp_i(mrsp), .route_err_o(rerr)
  );

  redmule_mesh_l2_axi_mux #(.N_TILES(3), .MAX_W_TRANS(8)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .slv_req_i(sreq3), .slv_rsp_o(srsp3),
    .mst_req_o(mreq3), .mst_rsp_i(mrsp3), .route_err_o(rerr3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] wd [4];
  int          exp_w [4];
  bit          pend [4];
  logic [3:0]  pid [4];
  logic [31:0] paddr [4];
  int          m_ptr, m_lock, w, pfx;
  logic        rdy;
  logic [5:0]  rid;
  logic [31:0] rdata;

  initial begin
    rst = 1'b1;
    sreq = '0; mrsp = '0; sreq3 = '0; mrsp3 = '0;
    // Reset: requests present on every side must not leak through.
    sreq[1].aw_valid = 1'b1;
    sreq[0].ar_valid = 1'b1;
    sreq[2].w_valid  = 1'b1;
    sreq[2].b_ready  = 1'b1;
    mrsp.b_valid     = 1'b1;
    mrsp.b.id        = 6'h23;
    mrsp.aw_ready    = 1'b1;
    #2;
    chk("rst_aw_valid", 64'(mreq.aw_valid), 64'(0));
    chk("rst_ar_valid", 64'(mreq.ar_valid), 64'(0));
    chk("rst_w_valid", 64'(mreq.w_valid), 64'(0));
    chk("rst_b_ready", 64'(mreq.b_ready), 64'(0));
    chk("rst_b_valid2", 64'(srsp[2].b_valid), 64'(0));
    chk("rst_aw_ready1", 64'(srsp[1].aw_ready), 64'(0));
    chk("rst_route_err", 64'(rerr), 64'(0));
    tick(); tick();
    rst = 1'b0;
    sreq = '0; mrsp = '0;

    // Single write from tile 2 with a two-cycle AW stall.
    tick();
    sreq[2].aw.id = 4'h3; sreq[2].aw.len = 8'd3; sreq[2].aw.addr = $urandom;
    sreq[2].aw_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin sreq[0].aw_valid = 1'b1; sreq[0].aw.id = 4'h7; end
      if (c == 2) mrsp.aw_ready = 1'b1;
      #1;
      chk("wr_aw_valid", 64'(mreq.aw_valid), 64'(1));
      chk("wr_aw_id", 64'(mreq.aw.id), 64'((2 << 4) | 3));
      chk("wr_aw_addr", 64'(mreq.aw.addr), 64'(sreq[2].aw.addr));
      chk("wr_aw_len", 64'(mreq.aw.len), 64'(3));
      chk("wr_aw_ready2", 64'(srsp[2].aw_ready), 64'(c == 2));
      chk("wr_aw_ready0", 64'(srsp[0].aw_ready), 64'(0));
      tick();
    end
    sreq[2].aw_valid = 1'b0; sreq[0].aw_valid = 1'b0; mrsp.aw_ready = 1'b0;
    mrsp.w_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wd[b] = $urandom;
      sreq[2].w.data = wd[b]; sreq[2].w.last = (b == 3); sreq[2].w_valid = 1'b1;
      #1;
      chk("wr_w_valid", 64'(mreq.w_valid), 64'(1));
      chk("wr_w_data", 64'(mreq.w.data), 64'(wd[b]));
      chk("wr_w_ready2", 64'(srsp[2].w_ready), 64'(1));
      tick();
    end
    sreq[2].w_valid = 1'b1;
    #1;
    chk("wr_w_after_empty", 64'(mreq.w_valid), 64'(0));
    chk("wr_w_ready_empty", 64'(srsp[2].w_ready), 64'(0));
    sreq[2].w_valid = 1'b0;
    mrsp.b_valid = 1'b1; mrsp.b.id = 6'h23; sreq[2].b_ready = 1'b1;
    #1;
    chk("wr_b_valid2", 64'(srsp[2].b_valid), 64'(1));
    chk("wr_b_id2", 64'(srsp[2].b.id), 64'(3));
    chk("wr_b_valid0", 64'(srsp[0].b_valid), 64'(0));
    chk("wr_b_ready", 64'(mreq.b_ready), 64'(1));
    tick();
    mrsp.b_valid = 1'b0; sreq[2].b_ready = 1'b0;

    // Round robin on AR: tiles 0,1,3 keep requesting.
    exp_w = '{0, 1, 3, 0};
    sreq[0].ar_valid = 1'b1; sreq[1].ar_valid = 1'b1; sreq[3].ar_valid = 1'b1;
    sreq[0].ar.id = 4'h1; sreq[1].ar.id = 4'h1; sreq[3].ar.id = 4'h1;
    mrsp.ar_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("rr_ar_valid", 64'(mreq.ar_valid), 64'(1));
      chk("rr_ar_id", 64'(mreq.ar.id), 64'((exp_w[g] << 4) | 1));
      for (int t = 0; t < 4; t++)
        chk("rr_ar_ready", 64'(srsp[t].ar_ready), 64'(t == exp_w[g]));
      tick();
    end
    sreq[0].ar_valid = 1'b0; sreq[1].ar_valid = 1'b0; sreq[3].ar_valid = 1'b0;
    mrsp.ar_ready = 1'b0;

    // W ordering: tile 1 (2 beats) then tile 0 (1 beat); tile 0 offers W early.
    rdata = $urandom;
    sreq[1].aw.len = 8'd1; sreq[1].aw_valid = 1'b1; mrsp.aw_ready = 1'b1;
    sreq[0].w.data = rdata; sreq[0].w.last = 1'b1; sreq[0].w_valid = 1'b1;
    #1;
    chk("ord_w_valid_empty", 64'(mreq.w_valid), 64'(0));
    chk("ord_w_ready0_empty", 64'(srsp[0].w_ready), 64'(0));
    tick();
    sreq[1].aw_valid = 1'b0; sreq[0].aw.len = 8'd0; sreq[0].aw_valid = 1'b1;
    #1;
    chk("ord_aw_ready0", 64'(srsp[0].aw_ready), 64'(1));
    chk("ord_w_valid_head1", 64'(mreq.w_valid), 64'(0));
    chk("ord_w_ready0_blk", 64'(srsp[0].w_ready), 64'(0));
    tick();
    sreq[0].aw_valid = 1'b0; mrsp.aw_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wd[b] = $urandom;
      sreq[1].w.data = wd[b]; sreq[1].w.last = (b == 1); sreq[1].w_valid = 1'b1;
      #1;
      chk("ord_t1_w_data", 64'(mreq.w.data), 64'(wd[b]));
      chk("ord_t1_w_ready", 64'(srsp[1].w_ready), 64'(1));
      chk("ord_t0_w_ready", 64'(srsp[0].w_ready), 64'(0));
      tick();
    end
    sreq[1].w_valid = 1'b0;
    #1;
    chk("ord_t0_w_valid", 64'(mreq.w_valid), 64'(1));
    chk("ord_t0_w_data", 64'(mreq.w.data), 64'(rdata));
    chk("ord_t0_w_ready", 64'(srsp[0].w_ready), 64'(1));
    tick();
    sreq[0].w_valid = 1'b0;
    #1;
    chk("ord_drained", 64'(mreq.w_valid), 64'(0));

    // FIFO full: 2-deep W FIFO, three AWs from tile 3 with no W.
    mrsp.aw_ready = 1'b1; sreq[3].aw_valid = 1'b1; sreq[3].w.last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sreq[3].aw.id = (c < 2) ? 4'(c + 1) : 4'h3;
      if (c == 3) begin sreq[3].w_valid = 1'b1; mrsp.w_ready = 1'b1; end
      #1;
      chk("full_aw_ready", 64'(srsp[3].aw_ready), 64'(c < 2));
      chk("full_aw_valid", 64'(mreq.aw_valid), 64'(c < 2));
      if (c == 3) chk("full_pop_w_ready", 64'(srsp[3].w_ready), 64'(1));
      tick();
    end
    sreq[3].w_valid = 1'b0;
    #1;
    chk("full_third_ready", 64'(srsp[3].aw_ready), 64'(1));
    chk("full_third_id", 64'(mreq.aw.id), 64'((3 << 4) | 3));
    tick();
    sreq[3].aw_valid = 1'b0; mrsp.aw_ready = 1'b0;
    sreq[3].w_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("full_drain_ready", 64'(srsp[3].w_ready), 64'(1));
      tick();
    end
    #1;
    chk("full_drained", 64'(mreq.w_valid), 64'(0));
    sreq[3].w_valid = 1'b0;

    // Reset in the middle of a 4-beat burst.
    sreq[2].aw.len = 8'd3; sreq[2].aw_valid = 1'b1; mrsp.aw_ready = 1'b1;
    tick();
    sreq[2].aw_valid = 1'b0; mrsp.aw_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      sreq[2].w.last = 1'b0; sreq[2].w_valid = 1'b1;
      tick();
    end
    #1;
    chk("mid_w_valid_b2", 64'(mreq.w_valid), 64'(1));
    sreq[1].aw_valid = 1'b1; sreq[0].ar_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_w_valid", 64'(mreq.w_valid), 64'(0));
    chk("mid_rst_w_ready", 64'(srsp[2].w_ready), 64'(0));
    chk("mid_rst_aw_valid", 64'(mreq.aw_valid), 64'(0));
    chk("mid_rst_ar_valid", 64'(mreq.ar_valid), 64'(0));
    chk("mid_rst_aw_ready1", 64'(srsp[1].aw_ready), 64'(0));
    tick();
    rst = 1'b0;
    sreq[1].aw_valid = 1'b0; sreq[0].ar_valid = 1'b0;
    #1;
    chk("mid_after_w_valid", 64'(mreq.w_valid), 64'(0));
    chk("mid_after_w_ready", 64'(srsp[2].w_ready), 64'(0));
    tick();
    sreq = '0; mrsp = '0;

    // Random AR traffic and R demux against a rule-level model.
    m_ptr = 0; m_lock = -1;
    for (int t = 0; t < 4; t++) pend[t] = 1'b0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      for (int t = 0; t < 4; t++) begin
        if (!pend[t] && $urandom_range(0, 1) == 1) begin
          pend[t] = 1'b1; pid[t] = 4'($urandom); paddr[t] = $urandom;
          sreq[t].ar.id = pid[t]; sreq[t].ar.addr = paddr[t]; sreq[t].ar_valid = 1'b1;
        end
        sreq[t].r_ready = 1'($urandom_range(0, 1));
      end
      rdy = 1'($urandom_range(0, 1));
      mrsp.ar_ready = rdy;
      rid = 6'($urandom); pfx = int'(rid[5:4]); rdata = $urandom;
      mrsp.r_valid = 1'($urandom_range(0, 1)); mrsp.r.id = rid; mrsp.r.data = rdata;
      w = -1;
      if (m_lock >= 0) w = m_lock;
      else for (int k = 0; k < 4; k++) if (w < 0 && pend[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      #1;
      chk("rnd_ar_valid", 64'(mreq.ar_valid), 64'(w >= 0));
      if (w >= 0) begin
        chk("rnd_ar_id", 64'(mreq.ar.id), 64'((w << 4) | int'(pid[w])));
        chk("rnd_ar_addr", 64'(mreq.ar.addr), 64'(paddr[w]));
      end
      for (int t = 0; t < 4; t++) begin
        chk("rnd_ar_ready", 64'(srsp[t].ar_ready), 64'(t == w && rdy));
        chk("rnd_r_valid", 64'(srsp[t].r_valid), 64'(t == pfx && mrsp.r_valid));
      end
      chk("rnd_r_ready", 64'(mreq.r_ready), 64'(sreq[pfx].r_ready));
      chk("rnd_r_id", 64'(srsp[pfx].r.id), 64'(rid[3:0]));
      chk("rnd_r_data", 64'(srsp[pfx].r.data), 64'(rdata));
      tick();
      if (w >= 0) begin
        if (rdy) begin
          pend[w] = 1'b0; sreq[w].ar_valid = 1'b0; m_ptr = (w + 1) % 4; m_lock = -1;
        end else begin
          m_lock = w;
        end
      end
    end
    chk("rnd_no_route_err", 64'(rerr), 64'(0));
    sreq = '0; mrsp = '0;

    // Out-of-range prefix on the 3-tile instance.
    mrsp3.r_valid = 1'b1; mrsp3.r.id = {2'd3, 4'h5};
    #1;
    chk("bad_r_ready", 64'(mreq3.r_ready), 64'(1));
    for (int t = 0; t < 3; t++) chk("bad_r_valid", 64'(srsp3[t].r_valid), 64'(0));
    chk("bad_err_not_yet", 64'(rerr3), 64'(0));
    tick();
    mrsp3.r_valid = 1'b0;
    #1;
    chk("bad_err_set", 64'(rerr3), 64'(1));
    tick();
    mrsp3.r_valid = 1'b1; mrsp3.r.id = {2'd1, 4'h2}; sreq3[1].r_ready = 1'b0;
    #1;
    chk("bad_err_sticky", 64'(rerr3), 64'(1));
    chk("good_r_valid1", 64'(srsp3[1].r_valid), 64'(1));
    chk("good_r_ready", 64'(mreq3.r_ready), 64'(0));
    rst = 1'b1;
    #1;
    chk("bad_err_cleared", 64'(rerr3), 64'(0));
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
